// File: rtl/data_sram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// data_sram_bridge_pkg
// Shared definitions for the CPU data-side to SRAM-style bus bridge:
//   - bridgeState_t : FSM state encoding (IDLE, REQ, WAIT, DONE)
//   - SIZE_*        : access size codes as presented on sizeM / size
//   - DEFAULT_PHYS_MASK : default virtual-to-physical address mask
//   - helpers for alignment checks and store lane formatting
// ---------------------------------------------------------------------------
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridgeState_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] DEFAULT_PHYS_MASK = 32'h1FFF_FFFF;

    // Reserved size 2'b11 falls into the word case everywhere below.
    function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            default:   bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] storeStrobe(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] strb;
        case (sz)
            SIZE_BYTE: strb = 4'b0001 << off;
            SIZE_HALF: strb = 4'b0011 << off;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data is replicated across all lanes so the strobe alone picks the target.
    function automatic logic [31:0] storeData(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            SIZE_BYTE: d = {4{wd[7:0]}};
            SIZE_HALF: d = {2{wd[15:0]}};
            default:   d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_sram_bridge_mem_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align
// Combinational load-lane selection and extension.
// Ports:
//   rdata    in  32  raw bus read word
//   offset   in  2   byte offset of the access (addr[1:0])
//   size     in  2   access size code (byte / half / word, 11 = word)
//   isSigned in  1   sign-extend when 1, zero-extend when 0
//   loadData out 32  right-justified, extended load value
// ---------------------------------------------------------------------------
module mem_load_align
    import data_sram_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] loadData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane = rdata[7:0];
        case (offset)
            2'd0: byteLane = rdata[7:0];
            2'd1: byteLane = rdata[15:8];
            2'd2: byteLane = rdata[23:16];
            2'd3: byteLane = rdata[31:24];
            default: byteLane = rdata[7:0];
        endcase

        // Halfword accesses are known aligned here, so only offset[1] matters.
        halfLane = offset[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_BYTE: loadData = {{24{isSigned & byteLane[7]}}, byteLane};
            SIZE_HALF: loadData = {{16{isSigned & halfLane[15]}}, halfLane};
            default:   loadData = rdata;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// ---------------------------------------------------------------------------
// data_sram_bridge
// Bridges the CPU memory stage to a request/acknowledge SRAM-style bus with a
// split address phase (addr_ok) and data phase (data_ok). One access at most
// is in flight; the CPU is stalled until the data phase completes.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   memenM, memwriteM     access valid, 1 = store / 0 = load
//   sizeM, signedM        access size code, load sign-extension select
//   aluoutM, writedataM   byte address, right-justified store data
//   readdataM             aligned, extended load result (held after DONE)
//   stallM                holds the CPU pipeline while an access is in flight
//   adelM, adesM          misaligned load / store flags (combinational)
//   req, wr, size         bus request, write flag, transfer size
//   addr, wdata, wstrb    physical address, lane-replicated data, byte strobes
//   addr_ok, data_ok      bus address-phase / data-phase acknowledges
//   rdata                 bus read data
// ---------------------------------------------------------------------------
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter logic [31:0] PHYS_MASK = DEFAULT_PHYS_MASK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        signedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    bridgeState_t state;
    bridgeState_t nextState;

    logic        misaligned;
    logic        launch;
    logic        capture;
    logic        ldSigned;
    logic [31:0] loadData;

    assign misaligned = isMisaligned(sizeM, aluoutM[1:0]);

    always_comb begin
        nextState = state;
        stallM    = 1'b0;
        adelM     = 1'b0;
        adesM     = 1'b0;
        req       = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                if (memenM) begin
                    if (misaligned) begin
                        // Exception path: flag it and let the pipeline move on.
                        adelM = ~memwriteM;
                        adesM = memwriteM;
                    end else begin
                        stallM    = 1'b1;
                        launch    = 1'b1;
                        nextState = REQ;
                    end
                end
            end
            REQ: begin
                req    = 1'b1;
                stallM = 1'b1;
                if (addr_ok) begin
                    if (data_ok) begin
                        capture   = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                stallM = 1'b1;
                if (data_ok) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                // Single release cycle; data_ok here is stale and ignored.
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        // Keep CPU-facing strobes quiet while reset is held, even if memenM is up.
        if (rst) begin
            stallM = 1'b0;
            adelM  = 1'b0;
            adesM  = 1'b0;
        end
    end

    // Reset abandons any access in flight; the bus side sees req drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr        <= 1'b0;
            size      <= 2'b00;
            addr      <= 32'h0;
            wdata     <= 32'h0;
            wstrb     <= 4'h0;
            ldSigned  <= 1'b0;
            readdataM <= 32'h0;
        end else begin
            state <= nextState;
            if (launch) begin
                wr       <= memwriteM;
                size     <= sizeM;
                addr     <= aluoutM & PHYS_MASK;
                wdata    <= storeData(sizeM, writedataM);
                wstrb    <= memwriteM ? storeStrobe(sizeM, aluoutM[1:0]) : 4'h0;
                ldSigned <= signedM;
            end
            if (capture) begin
                readdataM <= loadData;
            end
        end
    end

    // Lane select uses the registered request, which is stable until DONE.
    mem_load_align uLoadAlign (
        .rdata    (rdata),
        .offset   (addr[1:0]),
        .size     (size),
        .isSigned (ldSigned),
        .loadData (loadData)
    );

endmodule
